// File: rtl/conv_window_buf.sv
// Sliding KxK window generator over a raster pixel stream.
// Keeps the last K rows in circular row storage and emits strided windows with one cycle of latency.
module conv_window_buf #(
  parameter int WIDTH     = 12,
  parameter int HEIGHT    = 12,
  parameter int DATA_BITS = 12,
  parameter int K         = 5,
  parameter int STRIDE    = 1,
  parameter int CHANNELS  = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 frame_restart,
  input  logic                                 valid_in,
  input  logic [CHANNELS*DATA_BITS-1:0]        data_in,
  output logic [K*K*CHANNELS*DATA_BITS-1:0]    win_out,
  output logic                                 valid_out,
  output logic [$clog2(HEIGHT)-1:0]            out_row,
  output logic [$clog2(WIDTH)-1:0]             out_col,
  output logic                                 frame_done
);

  localparam int PIX_W = CHANNELS * DATA_BITS;
  localparam int WIN_W = K * K * PIX_W;
  localparam int RW    = $clog2(HEIGHT);
  localparam int CW    = $clog2(WIDTH);
  localparam int PW    = $clog2(K);
  localparam int PHW   = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [RW-1:0]  ROW_FIRST = RW'(K - 1);
  localparam logic [RW-1:0]  ROW_LAST  = RW'(HEIGHT - 1);
  localparam logic [CW-1:0]  COL_FIRST = CW'(K - 1);
  localparam logic [CW-1:0]  COL_LAST  = CW'(WIDTH - 1);
  localparam logic [PW-1:0]  PTR_LAST  = PW'(K - 1);
  localparam logic [PHW-1:0] PH_LAST   = PHW'(STRIDE - 1);

  logic [PIX_W-1:0] r_mem [K][WIDTH];

  logic [RW-1:0]    r_in_row;
  logic [CW-1:0]    r_in_col;
  logic [PW-1:0]    r_wptr;
  logic [PHW-1:0]   r_row_ph;
  logic [PHW-1:0]   r_col_ph;

  logic             r_valid_out;
  logic             r_frame_done;
  logic [WIN_W-1:0] r_win;
  logic [RW-1:0]    r_out_row;
  logic [CW-1:0]    r_out_col;

  logic             w_accept;
  logic             w_emit;
  logic             w_col_end;
  logic             w_last;
  logic [CW-1:0]    w_next_col;
  logic [RW-1:0]    w_next_row;
  logic [PW-1:0]    w_prow [K];
  logic [CW-1:0]    w_pcol [K];
  logic [WIN_W-1:0] w_win;

  // Physical storage row holding window row i: the oldest row sits just after the write pointer.
  function automatic logic [PW-1:0] phys_row(input logic [PW-1:0] ptr, input int i);
    int t;
    t = int'(ptr) + 1 + i;
    if (t >= K) t = t - K;
    return PW'(t);
  endfunction

  function automatic logic [CW-1:0] win_col(input logic [CW-1:0] col, input int j);
    return CW'(int'(col) - (K - 1) + j);
  endfunction

  assign w_accept   = valid_in && !frame_restart;
  assign w_col_end  = (r_in_col == COL_LAST);
  assign w_last     = w_col_end && (r_in_row == ROW_LAST);
  assign w_next_col = w_col_end ? '0 : r_in_col + 1'b1;
  assign w_next_row = (r_in_row == ROW_LAST) ? '0 : r_in_row + 1'b1;

  // Stride phases are zero exactly on window-aligned rows/columns, so no divider is needed.
  assign w_emit = w_accept && (r_in_row >= ROW_FIRST) && (r_in_col >= COL_FIRST) &&
                  (r_row_ph == '0) && (r_col_ph == '0);

  always_comb begin
    for (int i = 0; i < K; i++) begin
      w_prow[i] = phys_row(r_wptr, i);
      w_pcol[i] = win_col(r_in_col, i);
    end
  end

  // The bottom-right element is the pixel arriving this cycle; it is not in storage yet.
  always_comb begin
    w_win = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        if (i == K - 1 && j == K - 1) begin
          w_win[(i*K+j)*PIX_W +: PIX_W] = data_in;
        end else begin
          w_win[(i*K+j)*PIX_W +: PIX_W] = r_mem[w_prow[i]][w_pcol[j]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && rst_n) begin
      r_mem[r_wptr][r_in_col] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_row     <= '0;
      r_in_col     <= '0;
      r_wptr       <= '0;
      r_row_ph     <= '0;
      r_col_ph     <= '0;
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
      r_win        <= '0;
      r_out_row    <= '0;
      r_out_col    <= '0;
    end else if (frame_restart) begin
      r_in_row     <= '0;
      r_in_col     <= '0;
      r_wptr       <= '0;
      r_row_ph     <= '0;
      r_col_ph     <= '0;
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid_out  <= w_emit;
      r_frame_done <= valid_in && w_last;
      if (w_emit) begin
        r_win     <= w_win;
        r_out_row <= r_in_row - ROW_FIRST;
        r_out_col <= r_in_col - COL_FIRST;
      end
      if (valid_in) begin
        r_in_col <= w_next_col;
        if (w_next_col == COL_FIRST || r_col_ph == PH_LAST) r_col_ph <= '0;
        else r_col_ph <= r_col_ph + 1'b1;
        if (w_col_end) begin
          r_in_row <= w_next_row;
          r_wptr   <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
          if (w_next_row == ROW_FIRST || r_row_ph == PH_LAST) r_row_ph <= '0;
          else r_row_ph <= r_row_ph + 1'b1;
        end
      end
    end
  end

  assign win_out    = r_win;
  assign valid_out  = r_valid_out;
  assign out_row    = r_out_row;
  assign out_col    = r_out_col;
  assign frame_done = r_frame_done;

endmodule
